// File: rtl/prio_encoder_seq.sv
// Registered N-to-log2(N) priority encoder. Request pulses are latched into a pending register, and the winner is presented on a valid/ready port.
// Optional round-robin priority is enabled by the PRIO_ROTATE_EN macro. The default build uses fixed priority, where the highest index wins.
module prio_encoder_seq #(
   parameter int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic [N-1:0] d,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] pending,
   output logic         overflow
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_HOLD = 1'b1;

   logic [0:0]   state;
   logic         load;
   logic [N-1:0] cand;
   logic [W-1:0] win_idx;
   logic [N-1:0] g;

   assign out_valid = (state == S_HOLD);
   // A new winner is loaded when the output slot is empty or being consumed.
   assign load = (|pending) && (!out_valid || out_ready);

`ifdef PRIO_ROTATE_EN
   logic [W-1:0] last;
   logic [N-1:0] low_mask;
   logic [N-1:0] masked;

   // Priority descends from last-1 and wraps to N-1 when nothing lower is pending.
   always_comb begin
      low_mask = '0;
      for (int i = 0; i < N; i++) begin
         low_mask[i] = (i < int'(last));
      end
      masked = pending & low_mask;
      cand   = (|masked) ? masked : pending;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= '0;
      end else if (clr) begin
         last <= '0;
      end else if (load) begin
         last <= win_idx;
      end
   end
`else
   assign cand = pending;
`endif

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (cand[i]) begin
            win_idx = W'(i);
         end
      end
   end

   assign g = load ? ({{(N-1){1'b0}}, 1'b1} << win_idx) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         out_idx  <= '0;
         pending  <= '0;
         overflow <= 1'b0;
      end else if (clr) begin
         state    <= S_IDLE;
         out_idx  <= '0;
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         // If a set and a grant hit the same bit in one cycle, the set wins.
         pending  <= (pending & ~g) | d;
         overflow <= |(d & pending & ~g);
         if (load) begin
            state   <= S_HOLD;
            out_idx <= win_idx;
         end else if (out_valid && out_ready) begin
            state   <= S_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_prio_encoder_seq.sv
// Directed bench for prio_encoder_seq with N=8. It uses a vector table plus hand-written reset and rotation sequences.
module tb_prio_encoder_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic [7:0] d;
   logic       out_ready;
   logic       out_valid;
   logic [2:0] out_idx;
   logic [7:0] pending;
   logic       overflow;

   int checks = 0;
   int failures = 0;

   prio_encoder_seq #(.N(8)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .d(d), .out_ready(out_ready),
      .out_valid(out_valid), .out_idx(out_idx), .pending(pending), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       clr;
      logic [7:0] d;
      logic       rdy;
      logic       ev;
      logic       chk_idx;
      logic [2:0] ei;
      logic [7:0] ep;
      logic       eo;
   } vec_t;

   vec_t tbl[25];

   function automatic vec_t mk(input logic c, input logic [7:0] dd, input logic r,
                               input logic ev, input logic ci, input logic [2:0] ei,
                               input logic [7:0] ep, input logic eo);
      vec_t v;
      v.clr = c; v.d = dd; v.rdy = r; v.ev = ev; v.chk_idx = ci; v.ei = ei; v.ep = ep; v.eo = eo;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic c, input logic [7:0] dd, input logic r);
      @(negedge clk);
      clr = c; d = dd; out_ready = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; d = '0; out_ready = 1'b0;
      #12;
      chk("rst_valid", {7'b0, out_valid}, 8'h00);
      chk("rst_pending", pending, 8'h00);
      chk("rst_idx", {5'b0, out_idx}, 8'h00);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_valid", {7'b0, out_valid}, 8'h00);
      chk("post_rst_pending", pending, 8'h00);

      //              clr d     rdy ev   ci   ei    ep     eo
      tbl[0]  = mk(0, 8'h04, 1, 0, 0, 3'd0, 8'h04, 0);  // single request
      tbl[1]  = mk(0, 8'h00, 1, 1, 1, 3'd2, 8'h00, 0);
      tbl[2]  = mk(0, 8'h00, 1, 0, 0, 3'd0, 8'h00, 0);
      tbl[3]  = mk(1, 8'h00, 1, 0, 1, 3'd0, 8'h00, 0);  // clr in idle
      tbl[4]  = mk(0, 8'h0A, 1, 0, 0, 3'd0, 8'h0A, 0);  // priority
      tbl[5]  = mk(0, 8'h00, 1, 1, 1, 3'd3, 8'h02, 0);
      tbl[6]  = mk(0, 8'h00, 1, 1, 1, 3'd1, 8'h00, 0);
      tbl[7]  = mk(0, 8'h00, 1, 0, 0, 3'd0, 8'h00, 0);
      tbl[8]  = mk(1, 8'h00, 0, 0, 1, 3'd0, 8'h00, 0);
      tbl[9]  = mk(0, 8'h0A, 0, 0, 0, 3'd0, 8'h0A, 0);  // backpressure
      tbl[10] = mk(0, 8'h00, 0, 1, 1, 3'd3, 8'h02, 0);
      tbl[11] = mk(0, 8'h00, 0, 1, 1, 3'd3, 8'h02, 0);
      tbl[12] = mk(0, 8'h00, 0, 1, 1, 3'd3, 8'h02, 0);
      tbl[13] = mk(0, 8'h00, 0, 1, 1, 3'd3, 8'h02, 0);
      tbl[14] = mk(0, 8'h00, 0, 1, 1, 3'd3, 8'h02, 0);
      tbl[15] = mk(0, 8'h02, 0, 1, 1, 3'd3, 8'h02, 1);  // merge -> overflow
      tbl[16] = mk(0, 8'h00, 0, 1, 1, 3'd3, 8'h02, 0);
      tbl[17] = mk(0, 8'h00, 1, 1, 1, 3'd1, 8'h00, 0);
      tbl[18] = mk(0, 8'h00, 1, 0, 0, 3'd0, 8'h00, 0);
      tbl[19] = mk(1, 8'h00, 0, 0, 1, 3'd0, 8'h00, 0);
      tbl[20] = mk(0, 8'h70, 0, 0, 0, 3'd0, 8'h70, 0);  // clear in HOLD
      tbl[21] = mk(0, 8'h00, 0, 1, 1, 3'd6, 8'h30, 0);
      tbl[22] = mk(0, 8'h30, 0, 1, 1, 3'd6, 8'h30, 1);
      tbl[23] = mk(1, 8'h01, 1, 0, 1, 3'd0, 8'h00, 0);
      tbl[24] = mk(0, 8'h00, 1, 0, 1, 3'd0, 8'h00, 0);

      for (int i = 0; i < 25; i++) begin
         drive(tbl[i].clr, tbl[i].d, tbl[i].rdy);
         chk($sformatf("vec%0d_valid", i), {7'b0, out_valid}, {7'b0, tbl[i].ev});
         chk($sformatf("vec%0d_pending", i), pending, tbl[i].ep);
         chk($sformatf("vec%0d_overflow", i), {7'b0, overflow}, {7'b0, tbl[i].eo});
         if (tbl[i].chk_idx) begin
            chk($sformatf("vec%0d_idx", i), {5'b0, out_idx}, {5'b0, tbl[i].ei});
         end
      end

      // Asynchronous reset mid-HOLD drops the grant with no replay.
      drive(0, 8'h28, 0);
      drive(0, 8'h00, 0);
      chk("pre_rst_hold_idx", {5'b0, out_idx}, 8'h05);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", {7'b0, out_valid}, 8'h00);
      chk("async_rst_idx", {5'b0, out_idx}, 8'h00);
      chk("async_rst_pending", pending, 8'h00);
      @(negedge clk); rst_n = 1'b1;
      drive(0, 8'h00, 1);
      chk("no_replay_valid", {7'b0, out_valid}, 8'h00);
      chk("no_replay_pending", pending, 8'h00);

      // Continuous d=8'h81 with ready held high.
      drive(1, 8'h00, 1);
      drive(0, 8'h81, 1);
      chk("rot_first_pending", pending, 8'h81);
      chk("rot_first_valid", {7'b0, out_valid}, 8'h00);
      for (int k = 0; k < 6; k++) begin
         logic [2:0] exp_idx;
`ifdef PRIO_ROTATE_EN
         exp_idx = (k % 2 == 0) ? 3'd7 : 3'd0;
`else
         exp_idx = 3'd7;
`endif
         drive(0, 8'h81, 1);
         chk($sformatf("rot%0d_valid", k), {7'b0, out_valid}, 8'h01);
         chk($sformatf("rot%0d_idx", k), {5'b0, out_idx}, {5'b0, exp_idx});
         chk($sformatf("rot%0d_overflow", k), {7'b0, overflow}, 8'h01);
      end
      drive(0, 8'h00, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
